// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Time-shares one combinational integer ALU between two requesters.
// One operation is in flight at a time: IDLE accepts a request, EXEC lets
// the ALU settle on buffered operands, RESP holds the captured result until
// the granted requester takes it.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester request handshake (bit i = requester i)
//   req_r1/req_r2         operands, requester i at [XLEN*i +: XLEN]
//   req_funct3/req_funct7 function select, requester i at [3*i +: 3] / [i]
//   rsp_valid/rsp_ready   per-requester response handshake
//   rsp_data/zero/overflow captured ALU result and flags
//   alu_r1/r2/funct3/funct7 ALU inputs, driven only from the operand buffer
//   alu_out/zero/overflow ALU outputs
//   busy                  high whenever an operation is in flight
//   ops_count             completed responses, wraps modulo 2^CNT_W
//
// Build option
//   ALU_SHARE_FIXED_PRIO_EN  when defined, requester 0 always wins contention;
//                            otherwise arbitration is round-robin.
module alu_share_arbiter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [2*XLEN-1:0] req_r1,
    input  logic [2*XLEN-1:0] req_r2,
    input  logic [5:0]        req_funct3,
    input  logic [1:0]        req_funct7,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [XLEN-1:0]   rsp_data,
    output logic              rsp_zero,
    output logic              rsp_overflow,
    output logic [XLEN-1:0]   alu_r1,
    output logic [XLEN-1:0]   alu_r2,
    output logic [2:0]        alu_funct3,
    output logic              alu_funct7,
    input  logic [XLEN-1:0]   alu_out,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    output logic              busy,
    output logic [CNT_W-1:0]  ops_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_r;
    logic   grant_r;     // requester owning the in-flight operation
    logic   grant_s;     // requester that would win in the current cycle
    logic   any_valid_s;
`ifndef ALU_SHARE_FIXED_PRIO_EN
    logic   last_r;      // requester whose response completed most recently
`endif

    // Arbitration: a lone requester wins; on contention the policy decides.
    always_comb begin
        any_valid_s = |req_valid;
        grant_s     = 1'b0;
        case (req_valid)
            2'b01:   grant_s = 1'b0;
            2'b10:   grant_s = 1'b1;
`ifdef ALU_SHARE_FIXED_PRIO_EN
            2'b11:   grant_s = 1'b0;
`else
            2'b11:   grant_s = ~last_r;
`endif
            default: grant_s = 1'b0;
        endcase
    end

    // Accept is combinational so the request is taken in the cycle it appears.
    always_comb begin
        req_ready = 2'b00;
        if ((state_r == IDLE) && any_valid_s) begin
            req_ready = grant_s ? 2'b10 : 2'b01;
        end else begin
            req_ready = 2'b00;
        end
    end

    // Sequencer: operand buffer, result capture, response and completion count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            grant_r      <= 1'b0;
`ifndef ALU_SHARE_FIXED_PRIO_EN
            last_r       <= 1'b1;
`endif
            alu_r1       <= '0;
            alu_r2       <= '0;
            alu_funct3   <= 3'b000;
            alu_funct7   <= 1'b0;
            rsp_valid    <= 2'b00;
            rsp_data     <= '0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
            busy         <= 1'b0;
            ops_count    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_valid_s) begin
                        alu_r1     <= grant_s ? req_r1[2*XLEN-1:XLEN] : req_r1[XLEN-1:0];
                        alu_r2     <= grant_s ? req_r2[2*XLEN-1:XLEN] : req_r2[XLEN-1:0];
                        alu_funct3 <= grant_s ? req_funct3[5:3] : req_funct3[2:0];
                        alu_funct7 <= grant_s ? req_funct7[1] : req_funct7[0];
                        grant_r    <= grant_s;
                        busy       <= 1'b1;
                        state_r    <= EXEC;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                EXEC: begin
                    // ALU inputs have been stable for the whole cycle.
                    rsp_data     <= alu_out;
                    rsp_zero     <= alu_zero;
                    rsp_overflow <= alu_overflow;
                    rsp_valid    <= grant_r ? 2'b10 : 2'b01;
                    state_r      <= RESP;
                end
                RESP: begin
                    // Only the granted requester's ready can complete.
                    if (rsp_ready[grant_r]) begin
`ifndef ALU_SHARE_FIXED_PRIO_EN
                        last_r    <= grant_r;
`endif
                        ops_count <= ops_count + CNT_W'(1);
                        rsp_valid <= 2'b00;
                        busy      <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        state_r   <= RESP;
                    end
                end
                default: begin
                    rsp_valid <= 2'b00;
                    busy      <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed cases followed by
// randomized traffic, checked by a scoreboard against a transaction-level model.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  rsp_ready = 2'b00;
    logic [63:0] req_r1 = 64'd0;
    logic [63:0] req_r2 = 64'd0;
    logic [5:0]  req_funct3 = 6'd0;
    logic [1:0]  req_funct7 = 2'd0;

    logic [1:0]  req_ready, rsp_valid, req_ready2, rsp_valid2;
    logic [31:0] rsp_data, rsp_data2;
    logic        rsp_zero, rsp_overflow, rsp_zero2, rsp_overflow2;
    logic [31:0] alu_r1, alu_r2, alu_out, alu_r1_2, alu_r2_2, alu_out2;
    logic [2:0]  alu_funct3, alu_funct3_2;
    logic        alu_funct7, alu_zero, alu_overflow, alu_funct7_2, alu_zero2, alu_overflow2;
    logic        busy, busy2;
    logic [15:0] ops_count;
    logic [1:0]  ops_count2;

    always #5 clk = ~clk;

    // Reference integer ALU: returns {overflow/carry, zero, result}.
    function automatic logic [33:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] f3, input logic f7);
        logic [32:0] w;
        logic [31:0] r;
        logic        o;
        o = 1'b0;
        r = 32'd0;
        case (f3)
            3'd0: begin
                w = f7 ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
                r = w[31:0];
                o = w[32];
            end
            3'd1: r = a << b[4:0];
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: begin
                if (f7) r = $signed(a) >>> b[4:0];
                else    r = a >> b[4:0];
            end
            3'd6: r = a | b;
            3'd7: r = a & b;
            default: r = 32'd0;
        endcase
        return {o, (r == 32'd0), r};
    endfunction

    assign {alu_overflow, alu_zero, alu_out}    = alu_ref(alu_r1, alu_r2, alu_funct3, alu_funct7);
    assign {alu_overflow2, alu_zero2, alu_out2} = alu_ref(alu_r1_2, alu_r2_2, alu_funct3_2, alu_funct7_2);

    alu_share_arbiter #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_r1(req_r1), .req_r2(req_r2), .req_funct3(req_funct3), .req_funct7(req_funct7),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
        .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .busy(busy), .ops_count(ops_count)
    );

    // Narrow-counter instance sharing the same traffic, for the wrap check.
    alu_share_arbiter #(.XLEN(32), .CNT_W(2)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready2),
        .req_r1(req_r1), .req_r2(req_r2), .req_funct3(req_funct3), .req_funct7(req_funct7),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_data(rsp_data2),
        .rsp_zero(rsp_zero2), .rsp_overflow(rsp_overflow2),
        .alu_r1(alu_r1_2), .alu_r2(alu_r2_2), .alu_funct3(alu_funct3_2), .alu_funct7(alu_funct7_2),
        .alu_out(alu_out2), .alu_zero(alu_zero2), .alu_overflow(alu_overflow2),
        .busy(busy2), .ops_count(ops_count2)
    );

    typedef struct {
        logic        g;
        logic [31:0] d;
        logic        z;
        logic        o;
    } exp_t;

    exp_t sb[$];
    logic grant_log[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   ops_m = 0;
    logic last_m = 1'b1;
    bit   outstanding = 1'b0;
    int   age = 0;
    logic g_m;
    exp_t e_m;
    logic [33:0] r_m;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    // Monitor / scoreboard: samples on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            outstanding = 1'b0;
            last_m      = 1'b1;
            ops_m       = 0;
            chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_ops_count", 64'(ops_count), 64'd0);
            chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        end else begin
            chk("ops_count", 64'(ops_count), 64'(ops_m % 65536));
            chk("ops_count_wrap", 64'(ops_count2), 64'(ops_m % 4));
            if (!outstanding) begin
                chk("busy_idle", 64'(busy), 64'd0);
                chk("rsp_valid_idle", 64'(rsp_valid), 64'd0);
                if (req_valid != 2'b00) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
                    g_m = (req_valid == 2'b11) ? 1'b0 : req_valid[1];
`else
                    g_m = (req_valid == 2'b11) ? ~last_m : req_valid[1];
`endif
                    chk("req_ready_grant", 64'(req_ready), g_m ? 64'd2 : 64'd1);
                    r_m = alu_ref(g_m ? req_r1[63:32] : req_r1[31:0],
                                  g_m ? req_r2[63:32] : req_r2[31:0],
                                  g_m ? req_funct3[5:3] : req_funct3[2:0],
                                  req_funct7[g_m]);
                    e_m.g = g_m;
                    e_m.d = r_m[31:0];
                    e_m.z = r_m[32];
                    e_m.o = r_m[33];
                    sb.push_back(e_m);
                    grant_log.push_back(g_m);
                    outstanding = 1'b1;
                    age = 0;
                end else begin
                    chk("req_ready_none", 64'(req_ready), 64'd0);
                end
            end else begin
                age++;
                chk("req_ready_busy", 64'(req_ready), 64'd0);
                chk("busy_active", 64'(busy), 64'd1);
                if (age == 1) begin
                    chk("rsp_valid_exec", 64'(rsp_valid), 64'd0);
                end else begin
                    e_m = sb[0];
                    chk("rsp_valid", 64'(rsp_valid), e_m.g ? 64'd2 : 64'd1);
                    chk("rsp_data", 64'(rsp_data), 64'(e_m.d));
                    chk("rsp_zero", 64'(rsp_zero), 64'(e_m.z));
                    chk("rsp_overflow", 64'(rsp_overflow), 64'(e_m.o));
                    if (rsp_ready[e_m.g]) begin
                        void'(sb.pop_front());
                        last_m = e_m.g;
                        ops_m++;
                        outstanding = 1'b0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] f3, input logic f7);
        if (i == 0) begin
            req_r1[31:0] = a; req_r2[31:0] = b; req_funct3[2:0] = f3; req_funct7[0] = f7;
        end else begin
            req_r1[63:32] = a; req_r2[63:32] = b; req_funct3[5:3] = f3; req_funct7[1] = f7;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 2'b00;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic summary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    endtask

    // Watchdog: the run must not exceed its time budget.
    initial begin
        #400000;
        n_fail++;
        $display("FAIL watchdog: actual timeout required finish");
        summary();
        $finish;
    end

    logic ref_g[4];

    initial begin
        do_reset();

        // Reset while the operation is in EXEC: nothing is returned.
        set_req(0, 32'd9, 32'd3, 3'd0, 1'b0);
        rsp_ready = 2'b11;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("reset_exec_ops", 64'(ops_count), 64'd0);
        chk("reset_exec_rsp_valid", 64'(rsp_valid), 64'd0);

        // Single add request.
        set_req(0, 32'd5, 32'd7, 3'd0, 1'b0);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        chk("add_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("add_rsp_data", 64'(rsp_data), 64'd12);
        chk("add_rsp_zero", 64'(rsp_zero), 64'd0);
        tick();

        // Subtract to zero on requester 1.
        set_req(1, 32'h1234, 32'h1234, 3'd0, 1'b1);
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        tick();
        chk("sub_rsp_valid", 64'(rsp_valid), 64'd2);
        chk("sub_rsp_data", 64'(rsp_data), 64'd0);
        chk("sub_rsp_zero", 64'(rsp_zero), 64'd1);
        tick();
        chk("sub_ops_count", 64'(ops_count), 64'd2);

        // Contention straight after reset.
        do_reset();
        grant_log.delete();
        set_req(0, 32'd1, 32'd2, 3'd6, 1'b0);
        set_req(1, 32'd3, 32'd4, 3'd4, 1'b0);
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        repeat (12) tick();
        req_valid = 2'b00;
        tick();
`ifdef ALU_SHARE_FIXED_PRIO_EN
        ref_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        ref_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        chk("contention_count", 64'(grant_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
            chk("contention_grant", 64'(grant_log[i]), 64'(ref_g[i]));
        end

        // Response backpressure with the other requester waiting.
        set_req(0, 32'hFFFF_FFFF, 32'd1, 3'd0, 1'b0);
        rsp_ready = 2'b00;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b10;
        tick();
        repeat (5) begin
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            chk("bp_busy", 64'(busy), 64'd1);
            tick();
        end
        chk("bp_rsp_data", 64'(rsp_data), 64'd0);
        chk("bp_rsp_overflow", 64'(rsp_overflow), 64'd1);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b11;
        tick();
        req_valid = 2'b00;
        repeat (4) tick();

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            req_valid  = 2'($urandom);
            rsp_ready  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            req_r1     = {$urandom, $urandom};
            req_r2     = ($urandom_range(0, 3) == 0) ? req_r1 : {$urandom, $urandom};
            req_funct3 = 6'($urandom);
            req_funct7 = 2'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            tick();
        end

        // Drain.
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        repeat (5) tick();
        chk("drain_scoreboard_empty", 64'(sb.size()), 64'd0);
        chk("drain_busy", 64'(busy), 64'd0);

        summary();
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Sequencer that time-shares the single integer ALU between two requesters, for example the execute stage and the address/branch-compare path. It accepts one operation at a time over a valid/ready handshake and arbitrates round-robin. It drives the ALU operand and function inputs from a registered operand buffer, captures the result, zero and overflow outputs, and returns them to the granted requester over a valid/ready response channel. It also keeps a count of completed operations.

## Interface
- XLEN, 32: operand/result width; must match the ALU.
- CNT_W, 16: width of the completed-operation counter.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept; at most one bit set.
- req_r1  in  2*XLEN  operand 1; requester i at [XLEN*i +: XLEN].
- req_r2  in  2*XLEN  operand 2, same packing.
- req_funct3  in  6  funct3; requester i at [3*i +: 3].
- req_funct7  in  2  funct7 bit 5 per requester.
- rsp_valid  out  2  per-requester response valid; at most one bit set.
- rsp_ready  in  2  per-requester response accept.
- rsp_data  out  XLEN  ALU result, shared by both requesters.
- rsp_zero  out  1  captured ALU zero flag.
- rsp_overflow  out  1  captured ALU overflow/carry-out.
- alu_r1, alu_r2  out  XLEN  ALU operands.
- alu_funct3  out  3  ALU funct3.
- alu_funct7  out  1  ALU funct7 bit.
- alu_out  in  XLEN  ALU result, combinational from the alu_* outputs.
- alu_zero, alu_overflow  in  1  ALU flags.
- busy  out  1  high in any state other than IDLE.
- ops_count  out  CNT_W  completed responses, modulo 2^CNT_W.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid bit is set, pick grant g and assert req_ready[g] combinationally in that same cycle.
  - On the clock edge, latch requester g's r1, r2, funct3 and funct7 into the operand buffer, store g, and go to EXEC.
  - If no req_valid bit is set, stay in IDLE.
- Arbitration:
  - Only one requester valid: that requester wins.
  - Both valid: the requester not served last wins.
  - The `last` pointer updates only when a response completes.
- EXEC: the ALU sees stable buffered operands for a full cycle. On the edge, capture alu_out, alu_zero and alu_overflow into the result registers and go to RESP.
- RESP:
  - Hold rsp_valid[g]=1 with rsp_data, rsp_zero and rsp_overflow stable.
  - On rsp_ready[g]=1: set last←g, increment ops_count, go to IDLE.
  - rsp_ready on the non-granted bit is ignored.
- alu_* outputs are always driven from the operand buffer, never directly from req_* inputs.
- req_ready is never asserted outside IDLE.
- A requester may hold or drop req_valid freely while another requester is being served.

## Timing
- Reset values:
  - State = IDLE; req_ready=0, rsp_valid=0, busy=0.
  - Operand buffer, rsp_data, rsp_zero, rsp_overflow, alu_* = 0; ops_count=0.
  - `last`=1, so requester 0 wins the first contention.
- Latency: request accepted at edge N; rsp_valid high during cycle N+2.
- Peak throughput: one operation per 3 cycles when rsp_ready is held high.
- Back-to-back: the edge that completes a response returns the FSM to IDLE. A pending request is accepted in the next cycle, with arbitration using the updated `last`.
- Reset mid-operation: the in-flight operation is dropped, no response is issued, and ops_count is not incremented.
- ops_count wraps from 2^CNT_W−1 to 0 without saturating.

## Configuration
- ALU_SHARE_FIXED_PRIO_EN:
  - Defined: requester 0 always wins contention, and `last` is unused.
  - Undefined: round-robin as described in Operation.
  - Handshake, latency and reset behaviour are identical in both builds.

## Test plan
- Single request: req0 r1=5, r2=7, funct3=000, funct7=0 → req_ready[0] in the accept cycle; two cycles later rsp_valid[0]=1, rsp_data=12, rsp_zero=0.
- Subtract to zero: req1 r1=r2=0x1234, funct7=1 → rsp_valid[1]=1, rsp_data=0, rsp_zero=1; ops_count increments by 1.
- Contention after reset: both valid continuously with rsp_ready=11 → grants 0,1,0,1. With the macro defined → grants 0,0,0,0.
- Response backpressure: rsp_ready[0]=0 for 5 cycles → rsp_data and flags stay stable, req_ready stays 00, busy=1; completion occurs on the first cycle with rsp_ready[0]=1.
- Reset in EXEC: rst_n asserted low → next cycle rsp_valid=00, busy=0, ops_count unchanged from its pre-reset value of 0.
- Counter wrap: CNT_W=2, five completed operations → ops_count reads 1.
